// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - filtered, stretched, staggered reset release for the edge-detection datapath
module reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int MIN_ASSERT  = 16,
    parameter int RELEASE_GAP = 8,
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              s_reset,
    input  logic              ext_reset_n,
    input  logic              sw_reset,
    output logic [NUM_CH-1:0] rst_n_out,
    output logic              rst_done,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] FILT_MAX  = CNT_W'(FILTER_LEN);
    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILTER_LEN - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MIN_ASSERT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(RELEASE_GAP - 1);
    localparam logic [CNT_W-1:0] CH_LAST   = CNT_W'(NUM_CH - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ext_sync;
    logic [CNT_W-1:0]       filt_cnt;
    logic                   ext_rst_active;

    state_t                 cur_state;
    state_t                 nxt_state;
    logic [CNT_W-1:0]       hold_cnt;
    logic [CNT_W-1:0]       nxt_hold_cnt;
    logic [CNT_W-1:0]       gap_cnt;
    logic [CNT_W-1:0]       nxt_gap_cnt;
    logic [CNT_W-1:0]       ch_idx;
    logic [CNT_W-1:0]       nxt_ch_idx;
    logic [NUM_CH-1:0]      nxt_rst_n;
    logic                   nxt_done;
    logic                   reset_event;

    assign ext_sync = sync_q[SYNC_STAGES-1];

    // Metastability chain for the asynchronous external reset; stage 0 samples the pin.
    always_ff @(posedge clk) begin
        if (s_reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ext_reset_n};
        end
    end

    // Assert on the first low sample, deassert only after FILTER_LEN consecutive highs.
    always_ff @(posedge clk) begin
        if (s_reset) begin
            filt_cnt       <= '0;
            ext_rst_active <= 1'b1;
        end else if (!ext_sync) begin
            filt_cnt       <= '0;
            ext_rst_active <= 1'b1;
        end else if (filt_cnt != FILT_MAX) begin
            filt_cnt <= filt_cnt + CNT_ONE;
            if (filt_cnt == FILT_LAST) begin
                ext_rst_active <= 1'b0;
            end
        end
    end

    // A new reset request outside ASSERT: the filtered external reset or a software pulse.
    assign reset_event = ext_rst_active || sw_reset;

    // Next-state and next-output logic; every output of the block is registered below.
    always_comb begin
        nxt_state    = cur_state;
        nxt_hold_cnt = hold_cnt;
        nxt_gap_cnt  = gap_cnt;
        nxt_ch_idx   = ch_idx;
        nxt_rst_n    = rst_n_out;
        nxt_done     = rst_done;

        if (cur_state == ST_ASSERT) begin
            // Software requests are meaningless while the external reset still owns us.
            nxt_rst_n    = '0;
            nxt_done     = 1'b0;
            nxt_hold_cnt = '0;
            if (!ext_rst_active) begin
                nxt_state = ST_HOLD;
            end
        end else if (reset_event) begin
            // External reset takes precedence; a software pulse is stretched through HOLD.
            nxt_rst_n    = '0;
            nxt_done     = 1'b0;
            nxt_hold_cnt = '0;
            nxt_gap_cnt  = '0;
            nxt_ch_idx   = '0;
            nxt_state    = ext_rst_active ? ST_ASSERT : ST_HOLD;
        end else begin
            case (cur_state)
                ST_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        nxt_state   = ST_RELEASE;
                        nxt_gap_cnt = '0;
                        nxt_ch_idx  = '0;
                    end else begin
                        nxt_hold_cnt = hold_cnt + CNT_ONE;
                    end
                end
                ST_RELEASE: begin
                    if (gap_cnt == GAP_LAST) begin
                        // Release exactly the channel at ch_idx; lower ones are already high.
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (CNT_W'(i) == ch_idx) begin
                                nxt_rst_n[i] = 1'b1;
                            end
                        end
                        nxt_gap_cnt = '0;
                        nxt_ch_idx  = ch_idx + CNT_ONE;
                        if (ch_idx == CH_LAST) begin
                            nxt_state = ST_DONE;
                            nxt_done  = 1'b1;
                        end
                    end else begin
                        nxt_gap_cnt = gap_cnt + CNT_ONE;
                    end
                end
                default: begin
                    nxt_rst_n = '1;
                    nxt_done  = 1'b1;
                end
            endcase
        end
    end

    // Sequencer state, counters and the registered reset outputs.
    always_ff @(posedge clk) begin
        if (s_reset) begin
            cur_state <= ST_ASSERT;
            hold_cnt  <= '0;
            gap_cnt   <= '0;
            ch_idx    <= '0;
            rst_n_out <= '0;
            rst_done  <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            hold_cnt  <= nxt_hold_cnt;
            gap_cnt   <= nxt_gap_cnt;
            ch_idx    <= nxt_ch_idx;
            rst_n_out <= nxt_rst_n;
            rst_done  <= nxt_done;
        end
    end

    assign state = cur_state;

endmodule
